// File: rtl/inst_dec_pkg.sv
// inst_dec_pkg: opcode constants and the decoded-entry type shared by the decode queue.
// The custom opcodes sit in the RISC-V custom-0/custom-1 slots.
package inst_dec_pkg;
    localparam logic [6:0] OP_IMM  = 7'h13;
    localparam logic [6:0] OP      = 7'h33;
    localparam logic [6:0] LOAD    = 7'h03;
    localparam logic [6:0] STORE   = 7'h23;
    localparam logic [6:0] BRANCH  = 7'h63;
    localparam logic [6:0] JAL     = 7'h6F;
    localparam logic [6:0] JALR    = 7'h67;
    localparam logic [6:0] LUI     = 7'h37;
    localparam logic [6:0] AUIPC   = 7'h17;
    localparam logic [6:0] XCH16R  = 7'h0B;
    localparam logic [6:0] CNZDECJ = 7'h2B;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;
endpackage

// File: rtl/inst_dec_core.sv
// inst_dec_core: combinational field/immediate decoder.
// INST_DEC_CUSTOM_OPS_EN makes XCH16R and CNZDECJ legal; otherwise they decode as illegal.
module inst_dec_core
    import inst_dec_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);
    logic [6:0] op;
    logic       custom;
    logic       legal;
    logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm, c_imm, imm;

    assign op = inst[6:0];
`ifdef INST_DEC_CUSTOM_OPS_EN
    assign custom = (op == XCH16R) || (op == CNZDECJ);
`else
    assign custom = 1'b0;
`endif
    assign legal = (inst[1:0] == 2'b11) && (custom || op == OP_IMM || op == OP || op == LOAD ||
                   op == STORE || op == BRANCH || op == JAL || op == JALR || op == LUI || op == AUIPC);

    assign i_imm = {{20{inst[31]}}, inst[31:20]};
    assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign u_imm = {inst[31:12], 12'b0};
    assign c_imm = {{25{inst[31]}}, inst[31:25]};

    // Illegal and R-type fall through to zero.
    assign imm = !legal ? 32'd0 :
                 (op == OP_IMM || op == LOAD || op == JALR || op == XCH16R) ? i_imm :
                 (op == STORE)              ? s_imm :
                 (op == BRANCH)             ? b_imm :
                 (op == JAL)                ? j_imm :
                 (op == LUI || op == AUIPC) ? u_imm :
                 (op == CNZDECJ)            ? c_imm : 32'd0;

    assign dec = '{opcode: op, funct3: inst[14:12], funct7: inst[31:25], rs1: inst[19:15],
                   rs2: inst[24:20], rd: inst[11:7], imm: imm, illegal: !legal};
endmodule

// File: rtl/inst_decode_queue.sv
// inst_decode_queue: decodes fetched instructions and buffers them in a DEPTH-entry FIFO.
// Custom opcode decode is enabled by INST_DEC_CUSTOM_OPS_EN (see inst_dec_core).
module inst_decode_queue
    import inst_dec_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [6:0]               out_opcode,
    output logic [2:0]               out_funct3,
    output logic [6:0]               out_funct7,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [4:0]               out_rd,
    output logic [31:0]              out_imm,
    output logic [PC_W-1:0]          out_pc,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    dec_t            mem    [DEPTH];
    logic [PC_W-1:0] pc_mem [DEPTH];
    logic [AW-1:0]   wp, rp;
    logic [AW:0]     count;
    logic            push, pop;
    dec_t            dec, head;

    inst_dec_core u_dec (.inst(in_inst), .dec(dec));

    assign in_ready  = count != FULL;
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count_o   = count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // Storage is not reset; a write dropped by flush is never exposed because the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp]    <= dec;
            pc_mem[wp] <= in_pc;
        end
    end

    assign head        = mem[rp];
    assign out_opcode  = head.opcode;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_rd      = head.rd;
    assign out_imm     = head.imm;
    assign out_illegal = head.illegal;
    assign out_pc      = pc_mem[rp];
endmodule

// File: tb/tb_inst_decode_queue.sv
// tb_inst_decode_queue: randomized scoreboard bench; a negedge monitor checks the DUT against a queue model.
module tb_inst_decode_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 0, rst = 1, flush_i = 0, in_valid = 0, out_ready = 0;
    logic [31:0]     in_inst = 0;
    logic [PC_W-1:0] in_pc = 0;
    logic            in_ready, out_valid, out_illegal;
    logic [6:0]      out_opcode, out_funct7;
    logic [2:0]      out_funct3;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic [31:0]     out_imm;
    logic [PC_W-1:0] out_pc;
    logic [CW-1:0]   count_o;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        ill;
        logic [PC_W-1:0] pc;
    } exp_t;

    exp_t q[$];
    int   total = 0, passed = 0;
    bit   armed = 0;

    inst_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_pc(out_pc), .out_illegal(out_illegal), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference decode straight from the ISA immediate layouts.
    function automatic exp_t ref_dec(input logic [31:0] i, input logic [PC_W-1:0] pc);
        exp_t e;
        e = '{op: i[6:0], f3: i[14:12], f7: i[31:25], rs1: i[19:15], rs2: i[24:20],
              rd: i[11:7], imm: 0, ill: 1, pc: pc};
        if (i[1:0] == 2'b11) begin
            e.ill = 0;
            case (i[6:0])
                7'h13, 7'h03, 7'h67: e.imm = 32'($signed(i[31:20]));
                7'h23: e.imm = 32'($signed({i[31:25], i[11:7]}));
                7'h63: e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
                7'h6F: e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
                7'h37, 7'h17: e.imm = {i[31:12], 12'h000};
                7'h33: e.imm = 0;
`ifdef INST_DEC_CUSTOM_OPS_EN
                7'h0B: e.imm = 32'($signed(i[31:20]));
                7'h2B: e.imm = 32'($signed(i[31:25]));
`endif
                default: e.ill = 1;
            endcase
        end
        return e;
    endfunction

    // Monitor: check state against the model, then advance the model by this cycle's handshakes.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            exp_t h;
            chk("count", 64'(count_o), 64'(q.size()));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
            if (q.size() != 0) begin
                h = q[0];
                chk("head", {out_opcode, out_funct3, out_funct7, out_rs1, out_rs2, out_rd, out_illegal},
                            {h.op, h.f3, h.f7, h.rs1, h.rs2, h.rd, h.ill});
                chk("head_imm", 64'(out_imm), 64'(h.imm));
                chk("head_pc", 64'(out_pc), 64'(h.pc));
            end
            if (rst || flush_i) q.delete();
            else begin
                bit do_push;
                do_push = in_valid && q.size() != DEPTH;
                if (out_ready && q.size() != 0) void'(q.pop_front());
                if (do_push) q.push_back(ref_dec(in_inst, in_pc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic r);
        in_valid = v; in_inst = inst; in_pc = $urandom(); out_ready = r;
        step();
    endtask

    logic [6:0] ops [13] = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
                             7'h0B, 7'h2B, 7'h7F, 7'h13};

    initial begin
        logic [31:0] r;
        int sel, n;
        step(); step();
        rst = 0;
        armed = 1;
        step();
        chk("reset_count", 64'(count_o), 0);
        chk("reset_ready", 64'(in_ready), 1);

        drive(1, 32'hFFF00093, 0);
        in_valid = 0;
        chk("addi_opcode", 64'(out_opcode), 64'h13);
        chk("addi_rd", 64'(out_rd), 1);
        chk("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
        chk("addi_illegal", 64'(out_illegal), 0);
        drive(0, 0, 1);
        drive(1, 32'hFE000EE3, 0);
        in_valid = 0;
        chk("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
        drive(0, 0, 1);
        drive(1, 32'h123452B7, 0);
        in_valid = 0;
        chk("lui_imm", 64'(out_imm), 64'h12345000);
        chk("lui_rd", 64'(out_rd), 5);
        drive(0, 0, 1);
        drive(1, 32'h0000007F, 0);
        in_valid = 0;
        chk("bad_illegal", 64'(out_illegal), 1);
        chk("bad_imm", 64'(out_imm), 0);
        drive(0, 0, 1);
        drive(1, 32'hFE00102B, 0);
        in_valid = 0;
`ifndef INST_DEC_CUSTOM_OPS_EN
        chk("cnzdecj_illegal", 64'(out_illegal), 1);
`endif
        drive(0, 0, 1);

        for (int i = 0; i < 5; i++) drive(1, 32'h00100013 + (i << 7), 0);
        in_valid = 0;
        chk("full_count", 64'(count_o), 4);
        chk("full_ready", 64'(in_ready), 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1);

        drive(1, 32'h00208033, 0);
        drive(1, 32'h00310133, 0);
        drive(1, 32'h004181B3, 1);
        in_valid = 0; out_ready = 0;
        chk("pushpop_count", 64'(count_o), 2);
        for (int i = 0; i < 8; i++) drive(1, 32'h00000013 | (i << 20), 1);
        drive(0, 0, 1); drive(0, 0, 1);

        for (int i = 0; i < 3; i++) drive(1, 32'h00A00093, 0);
        flush_i = 1;
        drive(1, 32'h00B00093, 0);
        flush_i = 0; in_valid = 0;
        chk("flush_count", 64'(count_o), 0);
        chk("flush_valid", 64'(out_valid), 0);
        for (int i = 0; i < 3; i++) drive(1, 32'h00C00093, 0);
        rst = 1;
        drive(1, 32'h00D00093, 1);
        rst = 0; in_valid = 0;
        chk("rst_count", 64'(count_o), 0);
        chk("rst_valid", 64'(out_valid), 0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            sel = $urandom_range(0, 12);
            flush_i = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, (sel == 11) ? r : {r[31:7], ops[sel]},
                  $urandom_range(0, 2) != 0);
        end
        flush_i = 0;

        in_valid = 0; out_ready = 1;
        n = 0;
        while (out_valid && n < 50) begin step(); n++; end
        chk("drain_timeout", 64'(out_valid), 0);
        armed = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
